vga_timing_generator: RTL and testbench



---
 rtl/vga_pkg.sv | 52 +++++
 rtl/vga_timing_generator_if.sv | 22 ++
 rtl/vga_timing_generator_pixel_clk_div.sv | 37 +++
 rtl/vga_timing_generator.sv | 93 +++++++++
 tb/tb_vga_timing_generator.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared raster constants, colour palette and counter helpers for the VGA timing
// generator and the rgb-producing blocks that consume its counts.
package vga_pkg;

  typedef logic [9:0]  count_t;
  typedef logic [11:0] rgb_t;

  localparam int unsigned CLK_DIV  = 32'd4;
  localparam int unsigned H_SYNC   = 32'd96;
  localparam int unsigned H_BP     = 32'd48;
  localparam int unsigned H_ACTIVE = 32'd640;
  localparam int unsigned H_FP     = 32'd16;
  localparam int unsigned V_SYNC   = 32'd2;
  localparam int unsigned V_BP     = 32'd33;
  localparam int unsigned V_ACTIVE = 32'd480;
  localparam int unsigned V_FP     = 32'd10;

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam count_t H_VIS_START = count_t'(H_SYNC + H_BP);
  localparam count_t H_VIS_END   = count_t'(H_SYNC + H_BP + H_ACTIVE - 32'd1);
  localparam count_t V_VIS_START = count_t'(V_SYNC + V_BP);
  localparam count_t V_VIS_END   = count_t'(V_SYNC + V_BP + V_ACTIVE - 32'd1);
  localparam count_t V_FP_START  = count_t'(V_SYNC + V_BP + V_ACTIVE);

  localparam rgb_t COLOR_BLACK  = 12'h000;
  localparam rgb_t COLOR_WHITE  = 12'hFFF;
  localparam rgb_t COLOR_RED    = 12'hF00;
  localparam rgb_t COLOR_GREEN  = 12'h0F0;
  localparam rgb_t COLOR_BLUE   = 12'h00F;
  localparam rgb_t COLOR_YELLOW = 12'hFF0;
  localparam rgb_t COLOR_CYAN   = 12'h0FF;
  localparam rgb_t COLOR_GREY   = 12'h888;

  // Modulo counter step: returns 0 after the last position, otherwise cnt+1.
  function automatic count_t wrap_inc(input count_t cnt, input count_t last);
    count_t res;
    if (cnt == last) begin
      res = 10'd0;
    end else begin
      res = cnt + 10'd1;
    end
    return res;
  endfunction

  // Inclusive range test used for the visible window on both axes.
  function automatic logic in_window(input count_t pos, input count_t lo, input count_t hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_generator_if.sv
// Raster timing bundle: the generator drives it (master), rgb blocks and the
// VGA pin drivers observe it (slave).
interface vga_timing_generator_if;
  import vga_pkg::*;

  logic   pixel_en;
  count_t hCount;
  count_t vCount;
  logic   hSync;
  logic   vSync;
  logic   bright;
  logic   frame_tick;

  modport master (
    output pixel_en, hCount, vCount, hSync, vSync, bright, frame_tick
  );

  modport slave (
    input pixel_en, hCount, vCount, hSync, vSync, bright, frame_tick
  );

endinterface

// File: rtl/vga_timing_generator_pixel_clk_div.sv
// Board-clock divider producing a registered one-clk pixel_en strobe every DIV
// clocks; the first strobe arrives on the DIV-th edge after reset release.
module pixel_clk_div
  import vga_pkg::*;
#(
  parameter int unsigned DIV = CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic pixel_en
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] DIV_LAST = W'(DIV - 32'd1);
  localparam logic [W-1:0] DIV_ONE  = W'(32'd1);

  logic [W-1:0] div_r;
  logic         pixel_en_r;

  // Divider wraps at DIV-1; the strobe is the registered wrap condition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r      <= '0;
      pixel_en_r <= 1'b0;
    end else begin
      if (div_r == DIV_LAST) begin
        div_r <= '0;
      end else begin
        div_r <= div_r + DIV_ONE;
      end
      pixel_en_r <= (div_r == DIV_LAST);
    end
  end

  assign pixel_en = pixel_en_r;

endmodule

// File: rtl/vga_timing_generator.sv
// 640x480@60Hz raster timing: pixel counters, active-low syncs, display enable
// and a once-per-frame tick at the start of the vertical front porch.
module vga_timing_generator #(
  parameter int unsigned CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_timing_generator_if.master vga
);

  localparam vga_pkg::count_t H_LAST      = vga_pkg::count_t'(H_SYNC + H_BP + H_ACTIVE + H_FP - 32'd1);
  localparam vga_pkg::count_t V_LAST      = vga_pkg::count_t'(V_SYNC + V_BP + V_ACTIVE + V_FP - 32'd1);
  localparam vga_pkg::count_t H_SYNC_END  = vga_pkg::count_t'(H_SYNC);
  localparam vga_pkg::count_t V_SYNC_END  = vga_pkg::count_t'(V_SYNC);
  localparam vga_pkg::count_t H_VIS_START = vga_pkg::count_t'(H_SYNC + H_BP);
  localparam vga_pkg::count_t H_VIS_END   = vga_pkg::count_t'(H_SYNC + H_BP + H_ACTIVE - 32'd1);
  localparam vga_pkg::count_t V_VIS_START = vga_pkg::count_t'(V_SYNC + V_BP);
  localparam vga_pkg::count_t V_VIS_END   = vga_pkg::count_t'(V_SYNC + V_BP + V_ACTIVE - 32'd1);
  localparam vga_pkg::count_t V_FP_START  = vga_pkg::count_t'(V_SYNC + V_BP + V_ACTIVE);

  logic            pixel_en_s;
  vga_pkg::count_t h_r;
  vga_pkg::count_t v_r;
  vga_pkg::count_t h_next_s;
  vga_pkg::count_t v_next_s;
  logic            hsync_r;
  logic            vsync_r;
  logic            bright_r;
  logic            frame_tick_r;

  pixel_clk_div #(
    .DIV (CLK_DIV)
  ) u_pixel_clk_div (
    .clk      (clk),
    .rst      (rst),
    .pixel_en (pixel_en_s)
  );

  // Next raster position; counts only move on the pixel strobe.
  always_comb begin
    h_next_s = h_r;
    v_next_s = v_r;
    if (pixel_en_s) begin
      h_next_s = vga_pkg::wrap_inc(h_r, H_LAST);
      if (h_r == H_LAST) begin
        v_next_s = vga_pkg::wrap_inc(v_r, V_LAST);
      end else begin
        v_next_s = v_r;
      end
    end else begin
      h_next_s = h_r;
      v_next_s = v_r;
    end
  end

  // Counts and decodes are registered from the next position so syncs and
  // bright switch on the same edge as the counts they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_r          <= 10'd0;
      v_r          <= 10'd0;
      hsync_r      <= 1'b0;
      vsync_r      <= 1'b0;
      bright_r     <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      h_r          <= h_next_s;
      v_r          <= v_next_s;
      hsync_r      <= (h_next_s >= H_SYNC_END);
      vsync_r      <= (v_next_s >= V_SYNC_END);
      bright_r     <= vga_pkg::in_window(h_next_s, H_VIS_START, H_VIS_END) &&
                      vga_pkg::in_window(v_next_s, V_VIS_START, V_VIS_END);
      frame_tick_r <= pixel_en_s && (h_next_s == 10'd0) && (v_next_s == V_FP_START);
    end
  end

  assign vga.pixel_en   = pixel_en_s;
  assign vga.hCount     = h_r;
  assign vga.vCount     = v_r;
  assign vga.hSync      = hsync_r;
  assign vga.vSync      = vsync_r;
  assign vga.bright     = bright_r;
  assign vga.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: a default-timing instance for reset/divider/line checks and a
// scaled-down instance (17x12 raster, CLK_DIV=2) for frame-level behaviour.
module tb_vga_timing_generator;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  vga_timing_generator_if if_a ();
  vga_timing_generator_if if_b ();

  vga_timing_generator dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (if_a)
  );

  // Scaled raster: H 4+3+8+2=17, V 2+3+5+2=12, visible h 7..14, v 5..9, tick at (0,10).
  vga_timing_generator #(
    .CLK_DIV (2), .H_SYNC (4), .H_BP (3), .H_ACTIVE (8), .H_FP (2),
    .V_SYNC (2), .V_BP (3), .V_ACTIVE (5), .V_FP (2)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (if_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Per-run statistics of the scaled instance.
  int err_h, err_v, err_hs, err_vs, err_br, err_pe, err_tk;
  int tick_cnt, br_clks, vs_low_clks, hs_low_clks;
  int tick_e [0:3];

  // Bright-edge probe points on the scaled raster (first frame only).
  int probe_h  [0:5] = '{6, 7, 14, 15, 7, 7};
  int probe_v  [0:5] = '{5, 5, 9, 9, 4, 10};
  int probe_br [0:5] = '{0, 1, 1, 0, 0, 0};

  // Release rst_b at a negedge and compare every clock against a closed-form model.
  task automatic run_b(input int n_edges);
    int p, h, v, exp_tk;
    err_h = 0; err_v = 0; err_hs = 0; err_vs = 0; err_br = 0; err_pe = 0; err_tk = 0;
    tick_cnt = 0; br_clks = 0; vs_low_clks = 0; hs_low_clks = 0;
    for (int k = 0; k < 4; k++) tick_e[k] = 0;
    rst_b = 1'b1;
    for (int e = 1; e <= n_edges; e++) begin
      @(negedge clk);
      p = (e - 1) / 2;
      h = p % 17;
      v = (p / 17) % 12;
      exp_tk = ((e % 2) == 1 && e >= 3 && h == 0 && v == 10) ? 1 : 0;
      if (int'(if_b.hCount) != h) err_h++;
      if (int'(if_b.vCount) != v) err_v++;
      if (if_b.hSync !== (h >= 4)) err_hs++;
      if (if_b.vSync !== (v >= 2)) err_vs++;
      if (if_b.bright !== (h >= 7 && h <= 14 && v >= 5 && v <= 9)) err_br++;
      if (if_b.pixel_en !== ((e % 2) == 0)) err_pe++;
      if (int'(if_b.frame_tick) != exp_tk) err_tk++;
      if (if_b.frame_tick) begin
        if (tick_cnt < 4) tick_e[tick_cnt] = e;
        tick_cnt++;
      end
      if (if_b.bright) br_clks++;
      if (!if_b.vSync) vs_low_clks++;
      if (!if_b.hSync) hs_low_clks++;
      for (int k = 0; k < 6; k++) begin
        if (e == 1 + 2 * (probe_v[k] * 17 + probe_h[k]))
          chk($sformatf("b_bright_%0d_%0d", probe_h[k], probe_v[k]), if_b.bright, probe_br[k]);
      end
      if (e == 407) chk("b_pre_wrap_hv", {if_b.vCount, if_b.hCount}, {10'd11, 10'd16});
      if (e == 409) chk("b_post_wrap_hv", {if_b.vCount, if_b.hCount}, {10'd0, 10'd0});
    end
  endtask

  task automatic model_checks_b(input string tag);
    chk({tag, "_hcount"}, err_h, 0);
    chk({tag, "_vcount"}, err_v, 0);
    chk({tag, "_hsync"}, err_hs, 0);
    chk({tag, "_vsync"}, err_vs, 0);
    chk({tag, "_bright"}, err_br, 0);
    chk({tag, "_pixel_en"}, err_pe, 0);
    chk({tag, "_frame_tick"}, err_tk, 0);
  endtask

  int hs_low, pe_cnt, h_err, v_err, br_cnt, vs_high;

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;

    // ---- default instance: async reset mid-count, divider, first line ----
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    repeat (10) @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("a_async_reset", {if_a.pixel_en, if_a.hCount, if_a.vCount, if_a.hSync,
                          if_a.vSync, if_a.bright, if_a.frame_tick}, 32'd0);
    repeat (3) @(negedge clk);
    chk("a_reset_hold", {if_a.pixel_en, if_a.hCount, if_a.vCount, if_a.hSync,
                         if_a.vSync, if_a.bright, if_a.frame_tick}, 32'd0);
    rst_a = 1'b1;
    hs_low = 0; pe_cnt = 0; h_err = 0; v_err = 0; br_cnt = 0; vs_high = 0;
    for (int e = 1; e <= 3201; e++) begin
      @(negedge clk);
      if (e <= 8) chk($sformatf("a_pixel_en_edge%0d", e), if_a.pixel_en, ((e % 4) == 0));
      if (e <= 3200) begin
        if (!if_a.hSync) hs_low++;
        if (if_a.pixel_en) pe_cnt++;
        if (if_a.bright) br_cnt++;
        if (if_a.vSync) vs_high++;
        if (int'(if_a.hCount) != (e - 1) / 4) h_err++;
        if (if_a.vCount != 10'd0) v_err++;
      end
    end
    chk("a_hcount_wrap", if_a.hCount, 32'd0);
    chk("a_vcount_step", if_a.vCount, 32'd1);
    chk("a_hsync_low_clks", hs_low, 384);
    chk("a_pixel_en_per_line", pe_cnt, 800);
    chk("a_hcount_steps", h_err, 0);
    chk("a_vcount_hold", v_err, 0);
    chk("a_bright_line0", br_cnt, 0);
    chk("a_vsync_line0", vs_high, 0);

    // ---- scaled instance: three full frames from reset ----
    @(negedge clk);
    run_b(1224);
    model_checks_b("b_frames");
    chk("b_tick_count", tick_cnt, 3);
    chk("b_tick_first_edge", tick_e[0], 341);
    chk("b_tick_spacing1", tick_e[1] - tick_e[0], 408);
    chk("b_tick_spacing2", tick_e[2] - tick_e[1], 408);
    chk("b_bright_clks", br_clks, 240);
    chk("b_vsync_low_clks", vs_low_clks, 204);
    chk("b_hsync_low_clks", hs_low_clks, 288);

    // ---- scaled instance: reset asserted mid-frame at (10,7) ----
    rst_b = 1'b0;
    @(negedge clk);
    run_b(259);
    chk("b_mid_position", {if_b.vCount, if_b.hCount}, {10'd7, 10'd10});
    rst_b = 1'b0;
    #1;
    chk("b_mid_async_reset", {if_b.pixel_en, if_b.hCount, if_b.vCount, if_b.hSync,
                              if_b.vSync, if_b.bright, if_b.frame_tick}, 32'd0);
    tick_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (if_b.frame_tick || if_b.pixel_en || if_b.hCount != 10'd0) tick_cnt++;
    end
    chk("b_reset_quiet", tick_cnt, 0);
    run_b(360);
    model_checks_b("b_restart");
    chk("b_restart_tick_count", tick_cnt, 1);
    chk("b_restart_tick_edge", tick_e[0], 341);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
